// File: rtl/inst_encoder.sv
// Field-level instruction encoder: builds 16-bit ISA words from opcode/register/immediate
// requests and streams them into instruction memory starting at a programmed base address.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        op_in,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs0,
    input  logic [7:0]        imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Opcode values shared with the CPU decoder (def.h); 4'hF is unassigned.
    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_CMP   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SUBI  = 4'h6;
    localparam logic [3:0] OP_CMPI  = 4'h7;
    localparam logic [3:0] OP_LTI   = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;
    localparam logic [3:0] OP_JMPR  = 4'hD;
    localparam logic [3:0] OP_LI    = 4'hE;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_IMM     = 2'd2;
    localparam logic [1:0] ERR_ADDR    = 2'd3;

    typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                last_q, last_d;

    logic [15:0]         enc_word;
    logic                op_legal;
    logic                imm_ovf;

    always_comb begin
        enc_word = {op_in, 12'h000};
        op_legal = 1'b1;
        imm_ovf  = 1'b0;
        case (op_in)
            OP_AND, OP_OR, OP_ADD, OP_SUB:      enc_word = {op_in, rs1, rs0, rd};
            OP_CMP:                             enc_word = {op_in, rs1, rs0, 4'h0};
            OP_ADDI, OP_SUBI, OP_CMPI, OP_LTI:  enc_word = {op_in, rs1, imm};
            OP_LOAD, OP_JMPR: begin
                enc_word = {op_in, rs1, imm[3:0], rd};
                imm_ovf  = |imm[7:4];
            end
            OP_STORE: begin
                enc_word = {op_in, rs1, rs0, imm[3:0]};
                imm_ovf  = |imm[7:4];
            end
            OP_JMP, OP_JNZ, OP_LI:              enc_word = {op_in, imm, rd};
            default:                            op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        last_d     = last_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    addr_d     = base_addr;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (in_valid && in_ready_q) begin
                    if (!op_legal) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = ERR;
                    end else if (imm_ovf) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_IMM;
                        state_d    = ERR;
                    end else begin
                        wdata_d = enc_word;
                        last_d  = in_last;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + (ADDR_W+1)'(1);
                // Address never wraps: a full memory with more words pending is an error.
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (&addr_q) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_ADDR;
                    state_d    = ERR;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
        imem_we_d  = (state_d == WRITE);
        busy_d     = (state_d == RUN) || (state_d == WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            imem_we_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            imem_we_q  <= imem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            last_q     <= last_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_cnt   = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed scenarios plus random program loads,
// with expected memory writes queued at issue time and checked by an independent monitor.
module tb_inst_encoder;

    localparam int ADDR_W = 8;

    localparam logic [3:0] AND_OP = 4'h0, OR_OP = 4'h1, ADD_OP = 4'h2, SUB_OP = 4'h3;
    localparam logic [3:0] CMP_OP = 4'h4, ADDI_OP = 4'h5, SUBI_OP = 4'h6, CMPI_OP = 4'h7;
    localparam logic [3:0] LTI_OP = 4'h8, LOAD_OP = 4'h9, STORE_OP = 4'hA, JMP_OP = 4'hB;
    localparam logic [3:0] JNZ_OP = 4'hC, JMPR_OP = 4'hD, LI_OP = 4'hE, BAD_OP = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        op_in, rd, rs1, rs0;
    logic [7:0]        imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic [ADDR_W:0]   word_cnt;
    logic              busy, done, err;
    logic [1:0]        err_code;

    int checks = 0;
    int failures = 0;
    wr_t sb[$];

    // Reference model of the loader's architectural state.
    logic [ADDR_W-1:0] m_addr;
    int                m_cnt;
    logic              m_active, m_done, m_err;
    logic [1:0]        m_code;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op_in(op_in), .rd(rd), .rs1(rs1), .rs0(rs0), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_cnt(word_cnt), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic is_legal(input logic [3:0] op);
        return op != BAD_OP;
    endfunction

    function automatic logic has_ovf(input logic [3:0] op, input logic [7:0] im);
        return (op == LOAD_OP || op == JMPR_OP || op == STORE_OP) && (im > 8'd15);
    endfunction

    function automatic logic [15:0] encode(input logic [3:0] op, input logic [3:0] d,
                                           input logic [3:0] s1, input logic [3:0] s0,
                                           input logic [7:0] im);
        logic [15:0] w;
        w = 16'(op) << 12;
        if (op == AND_OP || op == OR_OP || op == ADD_OP || op == SUB_OP)
            w = w | (16'(s1) << 8) | (16'(s0) << 4) | 16'(d);
        else if (op == CMP_OP)
            w = w | (16'(s1) << 8) | (16'(s0) << 4);
        else if (op == ADDI_OP || op == SUBI_OP || op == CMPI_OP || op == LTI_OP)
            w = w | (16'(s1) << 8) | 16'(im);
        else if (op == LOAD_OP || op == JMPR_OP)
            w = w | (16'(s1) << 8) | (16'(im % 16) << 4) | 16'(d);
        else if (op == STORE_OP)
            w = w | (16'(s1) << 8) | (16'(s0) << 4) | 16'(im % 16);
        else
            w = w | (16'(im) << 4) | 16'(d);
        return w;
    endfunction

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                checkOutput("wr_addr", 32'(imem_addr), 32'(e.addr));
                checkOutput("wr_data", 32'(imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
        checkOutput({tag, "_imem_we"}, 32'(imem_we), 0);
        checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 0);
        checkOutput({tag, "_imem_wdata"}, 32'(imem_wdata), 0);
        checkOutput({tag, "_word_cnt"}, 32'(word_cnt), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_err"}, 32'(err), 0);
        checkOutput({tag, "_err_code"}, 32'(err_code), 0);
    endtask

    task automatic checkStatus(input string tag);
        logic exp_busy;
        exp_busy = m_active && !m_done && !m_err;
        checkOutput({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(exp_busy));
        checkOutput({tag, "_done"}, 32'(done), 32'(m_done));
        checkOutput({tag, "_err"}, 32'(err), 32'(m_err));
        checkOutput({tag, "_err_code"}, 32'(err_code), 32'(m_code));
        checkOutput({tag, "_word_cnt"}, 32'(word_cnt), 32'(m_cnt));
        checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'(m_addr));
    endtask

    task automatic doStart(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        m_active = 1'b1; m_addr = b; m_cnt = 0;
        m_done = 1'b0; m_err = 1'b0; m_code = 2'd0;
    endtask

    // Offers one request and waits (bounded) for the handshake; called and returns at a negedge.
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s1,
                                 input logic [3:0] s0, input logic [7:0] im, input logic last,
                                 input logic expect_accept, input logic hold_valid);
        logic accepted;
        wr_t  e;
        op_in = op; rd = d; rs1 = s1; rs0 = s0; imm = im; in_last = last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (in_ready === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accept", 32'(accepted), 32'(expect_accept));
        if (accepted) begin
            if (!is_legal(op)) begin
                m_err = 1'b1; m_code = 2'd1;
            end else if (has_ovf(op, im)) begin
                m_err = 1'b1; m_code = 2'd2;
            end else begin
                e.addr = m_addr;
                e.data = encode(op, d, s1, s0, im);
                sb.push_back(e);
                m_cnt++;
                if (last) m_done = 1'b1;
                else if (m_addr == {ADDR_W{1'b1}}) begin m_err = 1'b1; m_code = 2'd3; end
                else m_addr = m_addr + 1'b1;
            end
            @(posedge clk);
            #1;
            if (!hold_valid) in_valid = 1'b0;
            @(negedge clk);
            checkOutput("ready_low_after_hs", 32'(in_ready), 0);
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput("ready_after_write", 32'(in_ready), 32'(m_active && !m_done && !m_err));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] fmt_ops [8];
        logic [3:0] rop;
        logic [7:0] rim;
        int         nwords;

        rst = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        op_in = '0; rd = '0; rs1 = '0; rs0 = '0; imm = '0;
        m_active = 1'b0; m_addr = '0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_code = 2'd0;
        #1 rst = 1'b1;
        #2 checkReset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkStatus("idle");

        $display("[TB] directed two-word load");
        doStart(8'h10);
        applyStimulus(ADD_OP, 4'h5, 4'h3, 4'h4, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(LI_OP, 4'h2, 4'h0, 4'h0, 8'hA5, 1'b1, 1'b1, 1'b0);
        checkStatus("two_word");

        $display("[TB] per-format sweep");
        fmt_ops = '{CMP_OP, ADDI_OP, LOAD_OP, STORE_OP, JMP_OP, JMPR_OP, JNZ_OP, LTI_OP};
        doStart(8'h50);
        for (int i = 0; i < 8; i++)
            applyStimulus(fmt_ops[i], 4'h3, 4'h1, 4'h2, 8'h07, (i == 7), 1'b1, 1'b0);
        checkStatus("sweep");

        $display("[TB] error paths and recovery");
        doStart(8'h30);
        applyStimulus(LOAD_OP, 4'h3, 4'h1, 4'h2, 8'h12, 1'b0, 1'b1, 1'b0);
        checkStatus("imm_ovf");
        doStart(8'h30);
        applyStimulus(BAD_OP, 4'h3, 4'h1, 4'h2, 8'h12, 1'b0, 1'b1, 1'b0);
        checkStatus("illegal_op");
        doStart(8'h30);
        checkStatus("err_cleared");
        applyStimulus(OR_OP, 4'h7, 4'h8, 4'h9, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(SUBI_OP, 4'h1, 4'hC, 4'h0, 8'hF0, 1'b1, 1'b1, 1'b0);
        checkStatus("resumed");

        $display("[TB] address overflow");
        doStart(8'hFE);
        applyStimulus(AND_OP, 4'h1, 4'h2, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(SUB_OP, 4'h4, 4'h5, 4'h6, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(CMPI_OP, 4'h0, 4'h7, 4'h0, 8'h33, 1'b0, 1'b0, 1'b0);
        checkStatus("addr_ovf");

        $display("[TB] reset during write");
        doStart(8'h20);
        op_in = ADD_OP; rd = 4'h1; rs1 = 4'h2; rs0 = 4'h3; imm = 8'h00; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("we_in_write", 32'(imem_we), 1);
        rst = 1'b1;
        #1;
        in_valid = 1'b0;
        checkReset("rst_mid_write");
        m_active = 1'b0; m_addr = '0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_code = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkStatus("no_resume_without_start");

        $display("[TB] start during RUN and valid held through WRITE");
        doStart(8'h40);
        start = 1'b1; base_addr = 8'h80;
        @(negedge clk);
        start = 1'b0;
        checkStatus("start_ignored");
        applyStimulus(ADD_OP, 4'h1, 4'h2, 4'h3, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(SUB_OP, 4'h4, 4'h5, 4'h6, 8'h00, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkStatus("no_duplicates");

        $display("[TB] random program loads");
        for (int p = 0; p < 8; p++) begin
            doStart(8'($urandom_range(0, 200)));
            nwords = $urandom_range(1, 8);
            for (int w = 0; w < nwords; w++) begin
                rop = 4'($urandom_range(0, 14));
                rim = 8'($urandom);
                if (rop == LOAD_OP || rop == STORE_OP || rop == JMPR_OP) rim = rim & 8'h0F;
                applyStimulus(rop, 4'($urandom), 4'($urandom), 4'($urandom), rim,
                              (w == nwords - 1), 1'b1, 1'b0);
            end
            checkStatus("random_load");
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Encodes the 16-bit instruction words of the CPU ISA from field-level requests (opcode, rd, rs1, rs0, imm). It writes the encoded words sequentially into instruction memory starting at a programmed base address. It sits between the program loader (testbench, UART or host) and the instruction-memory write port, and performs the inverse of the CPU decoder's field extraction. Opcode constants come from def.h.

Parameters:
ADDR_W, 8, instruction-memory address width (8-bit jump immediates give 256 words)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begin a program load at base_addr
base_addr  input  ADDR_W  first write address, sampled on start
in_valid  input  1  field request valid
in_ready  output  1  encoder can accept a request
in_last  input  1  request is the final instruction of the program
op_in  input  4  opcode (def.h value)
rd  input  4  destination register
rs1  input  4  source register 1
rs0  input  4  source register 0
imm  input  8  immediate
imem_we  output  1  instruction-memory write enable
imem_addr  output  ADDR_W  write address
imem_wdata  output  16  encoded instruction word
word_cnt  output  ADDR_W+1  words written since start
busy  output  1  state is RUN or WRITE
done  output  1  program load completed
err  output  1  load aborted
err_code  output  2  0 none, 1 illegal opcode, 2 immediate overflow, 3 address overflow

Behaviour:
- Reset (async): state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_cnt=0, busy=0, done=0, err=0, err_code=0.
- States: IDLE, RUN, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start: imem_addr<=base_addr, word_cnt<=0, clear done/err/err_code, go RUN. Start is ignored in RUN and WRITE.
- RUN: in_ready=1. A handshake (in_valid & in_ready) latches the encoded word into imem_wdata and latches in_last, then goes to WRITE.
- Encoding (bits 15:12 = op_in in every case):
  - AND/OR/ADD/SUB: {op,rs1,rs0,rd}
  - CMP: {op,rs1,rs0,4'h0}
  - ADDI/SUBI/CMPI/LTI: {op,rs1,imm}
  - LOAD and JMPR: {op,rs1,imm[3:0],rd}
  - STORE: {op,rs1,rs0,imm[3:0]}
  - JMP/JNZ/LI: {op,imm,rd}
- Errors detected in the handshake cycle; no write occurs and the state goes to ERR:
  - Illegal opcode (a value not defined in def.h): err_code=1.
  - imm[7:4]!=0 for LOAD, JMPR or STORE: err_code=2.
  - Illegal opcode takes priority over immediate overflow.
- WRITE: imem_we=1 for exactly one cycle at the current imem_addr; in_ready=0. Next cycle word_cnt+1, then:
  - If the latched in_last is set: go DONE and hold imem_addr at the last written address.
  - Else, if imem_addr is all-ones: go ERR with err_code=3 and hold imem_addr (no wrap).
  - Else: imem_addr+1 and go RUN.
- Latency: handshake in cycle N → imem_we in N+1 → in_ready high again in N+2. Peak throughput is one word per 2 cycles.
- done and err are levels held until the next start or rst. imem_we is never asserted outside WRITE.
- Reset mid-load: all state clears immediately. A write in flight is dropped (imem_we falls asynchronously).
- in_valid while in_ready=0 is ignored; the requester holds its fields until the handshake.

Test Plan:
- start, base_addr=8'h10; ADD rs1=3 rs0=4 rd=5 → imem_we at addr 10, wdata={ADD,4'h3,4'h4,4'h5}; LI imm=8'hA5 rd=2, in_last=1 → addr 11, wdata={LI,8'hA5,4'h2}; then done=1, word_cnt=2, busy=0.
- Per-format sweep: CMP, ADDI, LOAD, STORE, JMP, JMPR, JNZ, LTI with rs1=1 rs0=2 rd=3 imm=8'h07 (CMP's fourth nibble is 4'h0) → each wdata matches the encoding table; in_ready low for exactly one cycle per word.
- LOAD imm=8'h12 → err=1, err_code=2, no imem_we. Illegal opcode → err_code=1. A following start clears err and the load resumes.
- base_addr=8'hFE with 3 non-last requests → writes at FE and FF, then err_code=3, word_cnt=2, third request never accepted.
- rst asserted in the WRITE cycle → imem_we drops immediately; all outputs at reset values; start is required to resume.
- start pulsed during RUN and in_valid held during WRITE → both ignored; no duplicate writes.
